// File: rtl/lsu_mem_tagger.sv
// lsu_mem_tagger: tags LSU requests with free slot ids and rejoins out-of-order memory responses with their warp/rd
// Ports: clock/reset (async, active-low); core_req_* in -> mem_req_* out carrying the allocated tag;
// mem_resp_* in -> core_resp_* out through one output register; outstanding/idle/tag_err status.
module lsu_mem_tagger #(
  parameter int ARCH_LEN   = 32,
  parameter int LSU_LANES  = 16,
  parameter int NUM_WARPS  = 8,
  parameter int REG_BITS   = 8,
  parameter int TAG_BITS   = 32,
  parameter int NUM_TAGS   = 8,
  parameter int DATA_WIDTH = LSU_LANES * ARCH_LEN,
  parameter int WID        = $clog2(NUM_WARPS)
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        core_req_valid,
  output logic                        core_req_ready,
  input  logic                        core_req_store,
  input  logic [WID-1:0]              core_req_warp,
  input  logic [REG_BITS-1:0]         core_req_rd,
  input  logic [DATA_WIDTH-1:0]       core_req_address,
  input  logic [DATA_WIDTH-1:0]       core_req_data,
  input  logic [LSU_LANES-1:0]        core_req_mask,
  output logic                        mem_req_valid,
  input  logic                        mem_req_ready,
  output logic                        mem_req_store,
  output logic [TAG_BITS-1:0]         mem_req_tag,
  output logic [DATA_WIDTH-1:0]       mem_req_address,
  output logic [DATA_WIDTH-1:0]       mem_req_data,
  output logic [LSU_LANES-1:0]        mem_req_mask,
  input  logic                        mem_resp_valid,
  output logic                        mem_resp_ready,
  input  logic [TAG_BITS-1:0]         mem_resp_tag,
  input  logic [DATA_WIDTH-1:0]       mem_resp_data,
  input  logic [LSU_LANES-1:0]        mem_resp_valids,
  output logic                        core_resp_valid,
  input  logic                        core_resp_ready,
  output logic                        core_resp_store,
  output logic [WID-1:0]              core_resp_warp,
  output logic [REG_BITS-1:0]         core_resp_rd,
  output logic [DATA_WIDTH-1:0]       core_resp_data,
  output logic [LSU_LANES-1:0]        core_resp_valids,
  output logic [$clog2(NUM_TAGS):0]   outstanding,
  output logic                        idle,
  output logic                        tag_err
);
  localparam int TIW = $clog2(NUM_TAGS);
  logic [NUM_TAGS-1:0] busy;
  logic [TIW-1:0]      alloc_idx;
  logic [TIW-1:0]      resp_idx;
  logic                have_free;
  logic                req_fire;
  logic                resp_fire;
  logic                resp_hit;
  logic                meta_store [NUM_TAGS];
  logic [WID-1:0]      meta_warp [NUM_TAGS];
  logic [REG_BITS-1:0] meta_rd [NUM_TAGS];
  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) if (!busy[i]) alloc_idx = TIW'(i);
  end
  always_comb begin
    outstanding = '0;
    for (int i = 0; i < NUM_TAGS; i++) outstanding = outstanding + (TIW + 1)'(busy[i]);
  end
  assign have_free       = ~&busy;
  assign mem_req_valid   = core_req_valid & have_free;
  assign core_req_ready  = mem_req_ready & have_free;
  assign mem_req_store   = core_req_store;
  assign mem_req_address = core_req_address;
  assign mem_req_data    = core_req_data;
  assign mem_req_mask    = core_req_mask;
  assign mem_req_tag     = TAG_BITS'(alloc_idx);
  assign req_fire        = mem_req_valid & mem_req_ready;
  assign mem_resp_ready  = ~core_resp_valid | core_resp_ready;
  assign resp_fire       = mem_resp_valid & mem_resp_ready;
  assign resp_idx        = mem_resp_tag[TIW-1:0];
  assign resp_hit        = resp_fire && mem_resp_tag < TAG_BITS'(NUM_TAGS) && busy[resp_idx];
  assign idle            = outstanding == '0 && !core_resp_valid;
  // alloc never picks a busy tag and a hit needs a busy tag, so set and clear never collide
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy            <= '0;
      core_resp_valid <= 1'b0;
      tag_err         <= 1'b0;
    end else begin
      busy            <= (busy | (req_fire ? NUM_TAGS'(1) << alloc_idx : '0)) & ~(resp_hit ? NUM_TAGS'(1) << resp_idx : '0);
      core_resp_valid <= resp_hit | (core_resp_valid & ~core_resp_ready);
      tag_err         <= tag_err | (resp_fire & ~resp_hit);
    end
  end
  always_ff @(posedge clock) begin
    if (req_fire) begin
      meta_store[alloc_idx] <= core_req_store;
      meta_warp[alloc_idx]  <= core_req_warp;
      meta_rd[alloc_idx]    <= core_req_rd;
    end
    if (resp_hit) begin
      core_resp_store  <= meta_store[resp_idx];
      core_resp_warp   <= meta_warp[resp_idx];
      core_resp_rd     <= meta_rd[resp_idx];
      core_resp_data   <= mem_resp_data;
      core_resp_valids <= mem_resp_valids;
    end
  end
endmodule
